// File: rtl/uram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uram_arb_pkg
//  Description : Shared types and helpers for the UltraRAM port arbiter:
//                request owner, controller state, and end-to-end read
//                latency helper.
//  Ports       : none (package)
//  Options     : none
//  Revision    : 1.0 - initial release
// ============================================================================
package uram_arb_pkg;

    // Which requester a RAM access belongs to.
    typedef enum logic [0:0] {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    // Controller state: clear sweep, then normal arbitration.
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Accept cycle to rsp_valid cycle, in clocks, for a given RAM pipeline
    // depth: 1 (command register) + 1 (array read) + NBPIPE + 1 (RAM dout
    // register) + 1 (response register).
    function automatic int uram_arb_lat(input int nbpipe);
        return nbpipe + 4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uram_arb_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : uram_arb_tag_pipe
//  Description : Fixed-depth {valid, owner} shift register that follows each
//                RAM access through the RAM pipeline so the response can be
//                steered to the correct requester.
//  Ports       : clk, rst       - clock, synchronous active-high clear
//                in_valid/owner - tag entering the pipe this cycle
//                out_valid/owner- tag leaving the pipe (DEPTH cycles later)
//  Parameters  : DEPTH (>= 2)   - number of register stages
//  Revision    : 1.0 - initial release
// ============================================================================
module uram_arb_tag_pipe
    import uram_arb_pkg::*;
#(
    parameter int DEPTH = 5
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   in_valid,
    input  owner_e in_owner,
    output logic   out_valid,
    output owner_e out_owner
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_owner;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_owner <= '0;
        end else begin
            r_valid <= {r_valid[DEPTH-2:0], in_valid};
            r_owner <= {r_owner[DEPTH-2:0], in_owner};
        end
    end

    assign out_valid = r_valid[DEPTH-1];
    assign out_owner = owner_e'(r_owner[DEPTH-1]);

endmodule
`default_nettype wire

// File: rtl/uram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uram_port_arbiter
//  Description : Shares one single-port, read-first, pipelined UltraRAM
//                between requesters A and B with round-robin arbitration.
//                After reset the whole array is swept to zero; afterwards one
//                request per cycle is accepted and every read returns to its
//                owner at a fixed latency of NBPIPE+4 cycles.
//  Ports       : clk, rst                 - clock, sync active-high reset
//                {a,b}_valid/we/addr/din  - request inputs
//                {a,b}_ready              - request accepted (combinational)
//                {a,b}_rsp_valid/data     - response pulse and data
//                ram_mem_en/we/regce      - registered RAM controls
//                ram_addr/din, ram_dout   - RAM address/data
//                init_done                - clear sweep finished
//  Parameters  : AWIDTH, DWIDTH, NBPIPE (must match the RAM instance)
//  Options     : URAM_ARB_WRRSP_EN - write grants also return the old
//                (read-first) contents to their owner.
//  Revision    : 1.0 - initial release
// ============================================================================
module uram_port_arbiter
    import uram_arb_pkg::*;
#(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 72,
    parameter int NBPIPE = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic              a_we,
    input  logic [AWIDTH-1:0] a_addr,
    input  logic [DWIDTH-1:0] a_din,
    output logic              a_rsp_valid,
    output logic [DWIDTH-1:0] a_rsp_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic              b_we,
    input  logic [AWIDTH-1:0] b_addr,
    input  logic [DWIDTH-1:0] b_din,
    output logic              b_rsp_valid,
    output logic [DWIDTH-1:0] b_rsp_data,
    output logic              ram_mem_en,
    output logic              ram_we,
    output logic              ram_regce,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_din,
    input  logic [DWIDTH-1:0] ram_dout,
    output logic              init_done
);

    // The tag enters the pipe one cycle after accept (alongside the RAM
    // command) and must leave it on the cycle ram_dout is valid, so the
    // command and response registers account for two of the LAT cycles.
    localparam int                c_LAT       = uram_arb_lat(NBPIPE);
    localparam int                c_TAG_DEPTH = c_LAT - 2;
    localparam logic [AWIDTH-1:0] c_LAST_ADDR = {AWIDTH{1'b1}};

    state_e            r_state;
    logic [AWIDTH-1:0] r_init_cnt;
    owner_e            r_rr_ptr;      // side that wins the next tie
    logic              r_issue_valid;
    owner_e            r_issue_owner;

    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_push;
    logic              w_tag_valid;
    owner_e            w_tag_owner;

    // ------------------------------------------------------------------
    // Arbitration: single grant per cycle, pointer only breaks ties.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (r_state == ST_RUN) begin
            if (a_valid && b_valid) begin
                w_grant_a = (r_rr_ptr == OWN_A);
                w_grant_b = (r_rr_ptr == OWN_B);
            end else begin
                w_grant_a = a_valid;
                w_grant_b = b_valid;
            end
        end
    end

    assign a_ready = w_grant_a;
    assign b_ready = w_grant_b;

`ifdef URAM_ARB_WRRSP_EN
    assign w_push = w_grant_a | w_grant_b;
`else
    assign w_push = (w_grant_a & ~a_we) | (w_grant_b & ~b_we);
`endif

    // ------------------------------------------------------------------
    // Init sweep, RAM command registers and response registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_INIT;
            r_init_cnt    <= '0;
            init_done     <= 1'b0;
            r_rr_ptr      <= OWN_A;
            ram_mem_en    <= 1'b0;
            ram_we        <= 1'b0;
            ram_regce     <= 1'b0;
            ram_addr      <= '0;
            ram_din       <= '0;
            r_issue_valid <= 1'b0;
            r_issue_owner <= OWN_A;
            a_rsp_valid   <= 1'b0;
            b_rsp_valid   <= 1'b0;
            a_rsp_data    <= '0;
            b_rsp_data    <= '0;
        end else begin
            ram_regce     <= 1'b1;
            ram_mem_en    <= 1'b0;
            ram_we        <= 1'b0;
            r_issue_valid <= w_push;
            r_issue_owner <= w_grant_b ? OWN_B : OWN_A;

            case (r_state)
                ST_INIT: begin
                    ram_mem_en <= 1'b1;
                    ram_we     <= 1'b1;
                    ram_addr   <= r_init_cnt;
                    ram_din    <= '0;
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == c_LAST_ADDR) begin
                        r_state   <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_grant_a) begin
                        ram_mem_en <= 1'b1;
                        ram_we     <= a_we;
                        ram_addr   <= a_addr;
                        ram_din    <= a_din;
                        r_rr_ptr   <= OWN_B;
                    end else if (w_grant_b) begin
                        ram_mem_en <= 1'b1;
                        ram_we     <= b_we;
                        ram_addr   <= b_addr;
                        ram_din    <= b_din;
                        r_rr_ptr   <= OWN_A;
                    end
                end
                default: r_state <= ST_INIT;
            endcase

            // Only the owner's data register is updated; the other holds.
            a_rsp_valid <= w_tag_valid && (w_tag_owner == OWN_A);
            b_rsp_valid <= w_tag_valid && (w_tag_owner == OWN_B);
            if (w_tag_valid && (w_tag_owner == OWN_A)) begin
                a_rsp_data <= ram_dout;
            end
            if (w_tag_valid && (w_tag_owner == OWN_B)) begin
                b_rsp_data <= ram_dout;
            end
        end
    end

    uram_arb_tag_pipe #(
        .DEPTH (c_TAG_DEPTH)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (r_issue_valid),
        .in_owner  (r_issue_owner),
        .out_valid (w_tag_valid),
        .out_owner (w_tag_owner)
    );

endmodule
`default_nettype wire

// File: tb/tb_uram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uram_port_arbiter
//  Description : Self-checking bench for uram_port_arbiter (AWIDTH=4,
//                NBPIPE=3) with a behavioural read-first UltraRAM and a
//                transaction-level reference model.
//  Ports       : none
//  Options     : URAM_ARB_WRRSP_EN - expect write responses
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uram_port_arbiter;

    localparam int AW    = 4;
    localparam int DW    = 72;
    localparam int NB    = 3;
    localparam int DEPTH = 1 << AW;
    localparam int LAT   = NB + 4;
`ifdef URAM_ARB_WRRSP_EN
    localparam bit WRRSP = 1'b1;
`else
    localparam bit WRRSP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_valid = 1'b0, a_we = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_din = '0;
    logic          b_valid = 1'b0, b_we = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_din = '0;
    logic          a_ready, b_ready, a_rsp_valid, b_rsp_valid;
    logic [DW-1:0] a_rsp_data, b_rsp_data;
    logic          ram_mem_en, ram_we, ram_regce, init_done;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;

    always #5 clk = ~clk;

    uram_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .NBPIPE(NB)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
        .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
        .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
        .ram_mem_en(ram_mem_en), .ram_we(ram_we), .ram_regce(ram_regce),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .init_done(init_done)
    );

    // Behavioural read-first UltraRAM with NBPIPE output stages.
    logic [DW-1:0] rm_mem [DEPTH];
    logic [DW-1:0] rm_q, rm_dout;
    logic [DW-1:0] rm_pipe [NB];
    always @(posedge clk) begin
        if (ram_mem_en) begin
            rm_q <= rm_mem[ram_addr];
            if (ram_we) rm_mem[ram_addr] <= ram_din;
        end
        rm_pipe[0] <= rm_q;
        for (int i = 1; i < NB; i++) rm_pipe[i] <= rm_pipe[i-1];
        if (ram_regce) rm_dout <= rm_pipe[NB-1];
    end
    assign ram_dout = rm_dout;

    // Reference model state.
    typedef struct { int due; bit own_b; logic [DW-1:0] data; } rsp_t;
    typedef struct { int cyc; bit own_b; } gnt_t;
    typedef struct { int cyc; bit own_b; logic [DW-1:0] data; } act_t;

    int            n_tests = 0, n_fail = 0, cyc = 0;
    bit            m_prev_rst = 1'b0, m_ptr_b = 1'b0;
    int            m_init_left = DEPTH;
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_last_a = '0, m_last_b = '0;
    rsp_t          m_q[$];
    gnt_t          g_log[$];
    act_t          act_log[$];
    bit            e_en = 0, e_we = 0, e_regce = 0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_din = '0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    task automatic set_a(input logic v, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        a_valid = v; a_we = w; a_addr = ad; a_din = d;
    endtask

    task automatic set_b(input logic v, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        b_valid = v; b_we = w; b_addr = ad; b_din = d;
    endtask

    task automatic idle();
        set_a(0, 0, '0, '0);
        set_b(0, 0, '0, '0);
    endtask

    // One clock cycle: check outputs mid-cycle, advance the model, step.
    task automatic tick();
        bit ga, gb, av, bv, we;
        logic [AW-1:0] ad;
        logic [DW-1:0] dn;
        rsp_t r;
        gnt_t g;
        act_t e;
        @(negedge clk);
        ga = 0; gb = 0; av = 0; bv = 0;
        if (rst && m_prev_rst) begin
            chk("rst_a_ready", a_ready, 0);
            chk("rst_b_ready", b_ready, 0);
            chk("rst_a_rsp_valid", a_rsp_valid, 0);
            chk("rst_b_rsp_valid", b_rsp_valid, 0);
            chk("rst_a_rsp_data", a_rsp_data, 0);
            chk("rst_b_rsp_data", b_rsp_data, 0);
            chk("rst_init_done", init_done, 0);
            chk("rst_ram_mem_en", ram_mem_en, 0);
            chk("rst_ram_we", ram_we, 0);
            chk("rst_ram_regce", ram_regce, 0);
        end else if (!rst) begin
            if (m_init_left == 0) begin
                if (a_valid && b_valid) begin
                    ga = !m_ptr_b;
                    gb = m_ptr_b;
                end else begin
                    ga = a_valid;
                    gb = b_valid;
                end
            end
            chk("a_ready", a_ready, ga);
            chk("b_ready", b_ready, gb);
            chk("init_done", init_done, m_init_left == 0);
            chk("ram_mem_en", ram_mem_en, e_en);
            chk("ram_we", ram_we, e_we);
            chk("ram_regce", ram_regce, e_regce);
            if (e_en) begin
                chk("ram_addr", ram_addr, e_addr);
                chk("ram_din", ram_din, e_din);
            end
            if (m_q.size() > 0 && m_q[0].due == cyc) begin
                if (m_q[0].own_b) begin bv = 1; m_last_b = m_q[0].data; end
                else begin av = 1; m_last_a = m_q[0].data; end
                void'(m_q.pop_front());
            end
            chk("a_rsp_valid", a_rsp_valid, av);
            chk("b_rsp_valid", b_rsp_valid, bv);
            chk("a_rsp_data", a_rsp_data, m_last_a);
            chk("b_rsp_data", b_rsp_data, m_last_b);
            if (a_rsp_valid) begin e.cyc = cyc; e.own_b = 0; e.data = a_rsp_data; act_log.push_back(e); end
            if (b_rsp_valid) begin e.cyc = cyc; e.own_b = 1; e.data = b_rsp_data; act_log.push_back(e); end
        end
        // Advance the model to the next cycle.
        if (rst) begin
            m_init_left = DEPTH;
            m_ptr_b = 0;
            m_q.delete();
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            m_last_a = '0; m_last_b = '0;
            e_en = 0; e_we = 0; e_regce = 0;
        end else begin
            e_regce = 1;
            if (m_init_left > 0) begin
                e_en = 1; e_we = 1; e_addr = AW'(DEPTH - m_init_left); e_din = '0;
                m_init_left--;
            end else if (ga || gb) begin
                we = ga ? a_we : b_we;
                ad = ga ? a_addr : b_addr;
                dn = ga ? a_din : b_din;
                e_en = 1; e_we = we; e_addr = ad; e_din = dn;
                if (!we || WRRSP) begin
                    r.due = cyc + LAT; r.own_b = gb; r.data = m_mem[ad];
                    m_q.push_back(r);
                end
                if (we) m_mem[ad] = dn;
                m_ptr_b = ga;
                g.cyc = cyc; g.own_b = gb;
                g_log.push_back(g);
            end else begin
                e_en = 0; e_we = 0;
            end
        end
        m_prev_rst = rst;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, nb, c0, s;

        // Reset, then INIT sweep with A already requesting.
        rst = 1; repeat (3) tick();
        rst = 0; c0 = cyc; n0 = act_log.size();
        set_a(1, 0, 4'd5, '0);
        repeat (16) tick();
        tick();
        idle(); repeat (10) tick();
        chk("init_first_accept_cycle", g_log[g_log.size()-1].cyc - c0, 16);
        chk("init_rd_count", act_log.size() - n0, 1);
        chk("init_rd_data", act_log[act_log.size()-1].data, 0);
        chk("init_rd_latency", act_log[act_log.size()-1].cyc - g_log[g_log.size()-1].cyc, 7);

        // Single requester write then read.
        n0 = act_log.size();
        set_a(1, 1, 4'd3, 72'hAB); tick();
        set_a(1, 0, 4'd3, '0); tick();
        idle(); repeat (10) tick();
        chk("single_rsp_count", act_log.size() - n0, WRRSP ? 2 : 1);
        chk("single_rd_data", act_log[act_log.size()-1].data, 72'hAB);
        chk("single_rd_latency", act_log[act_log.size()-1].cyc - g_log[g_log.size()-1].cyc, 7);
        nb = 0;
        for (int k = n0; k < act_log.size(); k++) if (act_log[k].own_b) nb++;
        chk("single_b_rsp_count", nb, 0);

        // Contention: a lone B read leaves A with tie priority.
        set_b(1, 0, 4'd0, '0); tick();
        set_a(1, 0, 4'd3, '0); set_b(1, 0, 4'd5, '0);
        repeat (6) tick();
        idle(); repeat (10) tick();
        for (int k = 0; k < 6; k++) begin
            chk("cont_grant_owner", g_log[g_log.size()-6+k].own_b, k % 2);
            chk("cont_rsp_owner", act_log[act_log.size()-6+k].own_b, k % 2);
            chk("cont_rsp_latency", act_log[act_log.size()-6+k].cyc - g_log[g_log.size()-6+k].cyc, 7);
        end

        // Read-first ordering across requesters.
        set_a(1, 1, 4'd9, 72'h11); tick();
        idle(); set_b(1, 1, 4'd9, 72'h22); tick();
        idle(); set_a(1, 0, 4'd9, '0); tick();
        idle(); repeat (10) tick();
        chk("rf_rd_owner", act_log[act_log.size()-1].own_b, 0);
        chk("rf_rd_data", act_log[act_log.size()-1].data, 72'h22);
        if (WRRSP) begin
            chk("rf_wr_rsp_owner", act_log[act_log.size()-2].own_b, 1);
            chk("rf_wr_rsp_data", act_log[act_log.size()-2].data, 72'h11);
        end

        // Randomized traffic against the model.
        repeat (300) begin
            set_a($urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom_range(0, DEPTH-1)), rnd_data());
            set_b($urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom_range(0, DEPTH-1)), rnd_data());
            tick();
        end
        idle(); repeat (10) tick();

        // Fill with a known pattern, then read back at full rate.
        n0 = act_log.size();
        for (int i = 0; i < DEPTH; i++) begin
            set_a(1, 1, AW'(i), DW'(i * 257)); tick();
        end
        for (int i = 0; i < DEPTH; i++) begin
            set_a(1, 0, AW'(i), '0); tick();
        end
        idle(); repeat (10) tick();
        chk("b2b_rsp_count", act_log.size() - n0, WRRSP ? 32 : 16);
        s = act_log.size() - 16;
        for (int k = 0; k < 16; k++) begin
            chk("b2b_data", act_log[s+k].data, DW'(k * 257));
            if (k > 0) chk("b2b_consecutive", act_log[s+k].cyc - act_log[s+k-1].cyc, 1);
        end

        // Reset three cycles after a read accept.
        n0 = act_log.size();
        set_a(1, 0, 4'd7, '0); tick();
        idle(); repeat (2) tick();
        rst = 1; repeat (3) tick();
        rst = 0; repeat (16) tick();
        chk("midrst_no_rsp", act_log.size() - n0, 0);
        set_a(1, 0, 4'd7, '0); tick();
        idle(); repeat (10) tick();
        chk("midrst_rd_count", act_log.size() - n0, 1);
        chk("midrst_rd_data", act_log[act_log.size()-1].data, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uram_port_arbiter.md
# uram_port_arbiter

- Shares one single-port, read-first, pipelined UltraRAM between two requesters (A, B) with round-robin arbitration.
- After reset, clears the whole array to zero, then accepts one request per cycle and returns each read to its owner at fixed latency.
- Sits directly in front of the UltraRAM wrapper and owns all of its control inputs.

## Interface
- AWIDTH, 12, address width; array depth 2^AWIDTH
- DWIDTH, 72, data width
- NBPIPE, 3, RAM output pipeline registers; must match the RAM instance
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset; also drives RAM rst
- a_valid / b_valid  in  1  request present
- a_ready / b_ready  out  1  request accepted this cycle (combinational)
- a_we / b_we  in  1  1 = write, 0 = read
- a_addr / b_addr  in  AWIDTH  request address
- a_din / b_din  in  DWIDTH  write data
- a_rsp_valid / b_rsp_valid  out  1  read data valid, one-cycle pulse
- a_rsp_data / b_rsp_data  out  DWIDTH  read data
- ram_mem_en, ram_we, ram_regce  out  1  RAM controls, registered
- ram_addr  out  AWIDTH, ram_din  out  DWIDTH  RAM address and data, registered
- ram_dout  in  DWIDTH  RAM output
- init_done  out  1  high once clear sweep is complete

## Operation
- States: INIT, RUN.
- rst forces INIT with init counter = 0.
  - Reset values: all outputs 0; RR pointer = A; tag pipe cleared.
- INIT behaviour:
  - Each cycle issues a write of 0 to address = counter, then increments.
  - On the cycle the last address (2^AWIDTH−1) is issued, move to RUN.
  - init_done is set on entry to RUN and stays 1 until rst.
- In INIT, a_ready = b_ready = 0.
- RUN arbitration:
  - Grant A if only A valid, B if only B valid.
  - If both valid, grant the side not granted last (pointer); the pointer updates only on a grant.
  - ready = valid & granted. At most one grant per cycle.
- Grant issue: next cycle ram_mem_en = 1, with ram_we/addr/din taken from the granted side; otherwise ram_mem_en = 0 and ram_we = 0.
- ram_regce is held at 1 in RUN and INIT; it is 0 only during rst.
- Tag pipe:
  - A {valid, owner} shift register of depth NBPIPE+2, aligned with the RAM read latency.
  - A tag is pushed for every granted read; write grants push nothing (default build).
- Response: when the tag emerges, ram_dout is registered into the owner's rsp_data and the owner's rsp_valid pulses for 1 cycle. The other side's rsp_data holds its value.
- Read-first semantics: a read following a write to the same address in the next cycle returns the new data. Ordering is preserved per requester and globally.
- There is no response backpressure; requesters must always accept rsp.
- rst mid-operation:
  - In-flight tags are discarded and no rsp_valid pulses for them.
  - The memory sweep restarts from address 0.

## Timing
- Request accepted in cycle T → ram_mem_en high in T+1.
- RAM dout valid in T+NBPIPE+3; rsp_valid in T+NBPIPE+4 (default 7 cycles).
- Throughput: 1 access per cycle total; each side gets at least 1 in 2 under contention.
- INIT lasts exactly 2^AWIDTH cycles after rst deasserts; the first request can be accepted in cycle 2^AWIDTH.

## Configuration
- URAM_ARB_WRRSP_EN defined:
  - Write grants also push a tag.
  - The owner receives rsp_valid with the old (read-first) contents at the same latency as a read.
  - INIT-sweep writes never generate responses.
- Undefined: writes produce no response.

## Structure
- Package uram_arb_pkg holds:
  - owner enum {OWN_A, OWN_B}
  - state enum {ST_INIT, ST_RUN}
  - LAT = NBPIPE+4 helper constant
- One sub-module, uram_arb_tag_pipe: a parameterised-depth {valid, owner} shift register with synchronous clear.
- The arbiter, init sweep and output registers stay in the top level.

## Test plan
- All bench scenarios use AWIDTH=4, NBPIPE=3, with a behavioural model of the RAM.
- Reset/INIT:
  - Deassert rst; a_valid held high.
  - Required: a_ready = 0 for 16 cycles and init_done rises at cycle 16.
  - A read of addr 5 then returns 0 seven cycles after accept.
- Single requester write/read:
  - A writes 0xAB to addr 3, next cycle A reads addr 3.
  - Required: a_rsp_valid 7 cycles after the read accept with data 0xAB; b_rsp_valid never asserts.
- Contention:
  - A and B both hold reads for 6 cycles.
  - Required: grants alternate A, B, A, B, A, B, and responses return in the same order at +7.
- Read-first: A writes 0x11 to addr 9, B writes 0x22 to addr 9, A reads addr 9 → 0x22.
  - With URAM_ARB_WRRSP_EN, B's write response carries 0x11.
- Reset mid-flight:
  - Assert rst 3 cycles after a read accept.
  - Required: no rsp_valid pulse, and the INIT sweep restarts at addr 0.
- Back-to-back full rate: A reads addrs 0..15 continuously → 16 consecutive a_rsp_valid pulses, data in address order.
